// File: rtl/regfile_mem_alu_if.sv
// Bus bundle for regfile_mem_alu: register-file ports, data-memory ports and adder/subtractor ports.
// The master drives the controls and operands, and the slave (the datapath core) drives the results.
interface regfile_mem_alu_if #(
    parameter int WORDSIZE = 64
);
    logic                rf_write_en;
    logic [4:0]          rf_write_addr;
    logic [WORDSIZE-1:0] rf_write_data;
    logic [4:0]          rf_addr_a;
    logic [4:0]          rf_addr_b;
    logic [WORDSIZE-1:0] rf_data_a;
    logic [WORDSIZE-1:0] rf_data_b;

    logic [4:0]          dm_addr;
    logic [WORDSIZE-1:0] dm_data_input;
    logic                dm_write_enable;
    logic                dm_read;
    logic [WORDSIZE-1:0] dm_data_output;

    logic [WORDSIZE-1:0] as_factor_a;
    logic [WORDSIZE-1:0] as_factor_b;
    logic                as_operation;
    logic [WORDSIZE-1:0] as_result;

    modport master (
        output rf_write_en, rf_write_addr, rf_write_data, rf_addr_a, rf_addr_b,
        output dm_addr, dm_data_input, dm_write_enable, dm_read,
        output as_factor_a, as_factor_b, as_operation,
        input  rf_data_a, rf_data_b, dm_data_output, as_result
    );

    modport slave (
        input  rf_write_en, rf_write_addr, rf_write_data, rf_addr_a, rf_addr_b,
        input  dm_addr, dm_data_input, dm_write_enable, dm_read,
        input  as_factor_a, as_factor_b, as_operation,
        output rf_data_a, rf_data_b, dm_data_output, as_result
    );
endinterface

// File: rtl/regfile_mem_alu.sv
// Storage-and-arithmetic core: a 32-entry register file, a 32-word data memory with registered read,
// and a combinational add/subtract unit. All of its state clears asynchronously on reset.
module regfile_mem_alu #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
) (
    input logic               clk,
    input logic               reset,
    regfile_mem_alu_if.slave  bus
);
    logic [WORDSIZE-1:0] rf  [SIZE];
    logic [WORDSIZE-1:0] mem [SIZE];
    logic [WORDSIZE-1:0] dm_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SIZE; i++) rf[i] <= '0;
        end else if (bus.rf_write_en) begin
            rf[bus.rf_write_addr] <= bus.rf_write_data;
        end
    end

    assign bus.rf_data_a = rf[bus.rf_addr_a];
    assign bus.rf_data_b = rf[bus.rf_addr_b];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SIZE; i++) mem[i] <= '0;
        end else if (bus.dm_write_enable) begin
            mem[bus.dm_addr] <= bus.dm_data_input;
        end
    end

    // Write-first: a simultaneous write and read returns the incoming data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_out <= '0;
        end else if (bus.dm_read) begin
            dm_out <= bus.dm_write_enable ? bus.dm_data_input : mem[bus.dm_addr];
        end
    end

    assign bus.dm_data_output = dm_out;

    assign bus.as_result = bus.as_operation ? (bus.as_factor_a - bus.as_factor_b)
                                            : (bus.as_factor_a + bus.as_factor_b);
endmodule

// File: tb/tb_regfile_mem_alu.sv
// Self-checking bench for regfile_mem_alu: directed corner sequences, an arithmetic vector table,
// and randomized traffic compared against an array-based reference model.
module tb_regfile_mem_alu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clk_go = 1'b0;

    int tests  = 0;
    int failed = 0;

    logic [63:0] rf_m  [32];
    logic [63:0] mem_m [32];
    logic [63:0] dout_m;

    regfile_mem_alu_if #(.WORDSIZE(64)) bus ();

    regfile_mem_alu #(.WORDSIZE(64), .SIZE(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        wait (clk_go);
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic [63:0] exp;
    } alu_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            rf_m[i]  = '0;
            mem_m[i] = '0;
        end
        dout_m = '0;
    endtask

    task automatic idle_inputs();
        bus.rf_write_en     = 1'b0;
        bus.rf_write_addr   = '0;
        bus.rf_write_data   = '0;
        bus.rf_addr_a       = '0;
        bus.rf_addr_b       = '0;
        bus.dm_addr         = '0;
        bus.dm_data_input   = '0;
        bus.dm_write_enable = 1'b0;
        bus.dm_read         = 1'b0;
        bus.as_factor_a     = '0;
        bus.as_factor_b     = '0;
        bus.as_operation    = 1'b0;
    endtask

    // One rising edge; the model applies the same inputs the DUT saw at that edge
    task automatic tick();
        logic        rwe, dwe, drd;
        logic [4:0]  rwa, da;
        logic [63:0] rwd, ddi;
        rwe = bus.rf_write_en;     rwa = bus.rf_write_addr; rwd = bus.rf_write_data;
        dwe = bus.dm_write_enable; drd = bus.dm_read;
        da  = bus.dm_addr;         ddi = bus.dm_data_input;
        @(posedge clk);
        #1;
        if (drd) dout_m = dwe ? ddi : mem_m[da];
        if (dwe) mem_m[da] = ddi;
        if (rwe) rf_m[rwa] = rwd;
    endtask

    alu_vec_t vecs [8];

    initial begin
        logic [63:0] exp_r;

        idle_inputs();
        model_clear();

        // Reset with no clock running
        #1 reset = 1'b1;
        #2;
        for (int i = 0; i < 32; i++) begin
            bus.rf_addr_a = 5'(i);
            bus.rf_addr_b = 5'(31 - i);
            #1;
            check("reset_rf_a", bus.rf_data_a, 64'h0);
            check("reset_rf_b", bus.rf_data_b, 64'h0);
        end
        check("reset_dm_out", bus.dm_data_output, 64'h0);
        #2 reset = 1'b0;
        #2 clk_go = 1'b1;
        #1;

        // Read mem[31] after reset
        bus.dm_addr = 5'd31; bus.dm_read = 1'b1;
        tick();
        check("mem31_after_reset", bus.dm_data_output, 64'h0);
        bus.dm_read = 1'b0;

        // RF write visible only after the edge; no bypass
        bus.rf_write_en = 1'b1; bus.rf_write_addr = 5'd4;
        bus.rf_write_data = 64'h0123_4567_89AB_CDEF;
        bus.rf_addr_a = 5'd4; bus.rf_addr_b = 5'd4;
        #1;
        check("rf_no_bypass", bus.rf_data_a, 64'h0);
        tick();
        check("rf_write_a", bus.rf_data_a, 64'h0123_4567_89AB_CDEF);
        check("rf_write_b", bus.rf_data_b, 64'h0123_4567_89AB_CDEF);
        bus.rf_write_addr = 5'd0; bus.rf_write_data = 64'd5;
        tick();
        bus.rf_write_en = 1'b0; bus.rf_addr_a = 5'd0;
        #1;
        check("rf_entry0_writable", bus.rf_data_a, 64'd5);

        // Store path with write-first
        bus.rf_write_en = 1'b1; bus.rf_write_addr = 5'd4; bus.rf_write_data = 64'hDEAD_BEEF;
        tick();
        bus.rf_write_en = 1'b0; bus.rf_addr_a = 5'd4;
        #1;
        bus.dm_addr = 5'd4; bus.dm_data_input = bus.rf_data_a;
        bus.dm_write_enable = 1'b1; bus.dm_read = 1'b1;
        tick();
        check("store_write_first", bus.dm_data_output, 64'hDEAD_BEEF);
        bus.dm_write_enable = 1'b0; bus.dm_data_input = '0;
        tick();
        check("store_readback", bus.dm_data_output, 64'hDEAD_BEEF);

        // Sequential store then read, then hold with dm_read low
        bus.dm_addr = 5'd7; bus.dm_data_input = 64'd9; bus.dm_write_enable = 1'b1; bus.dm_read = 1'b0;
        tick();
        check("store_no_read_holds", bus.dm_data_output, 64'hDEAD_BEEF);
        bus.dm_write_enable = 1'b0; bus.dm_read = 1'b1;
        tick();
        check("mem7_read", bus.dm_data_output, 64'd9);
        bus.dm_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.dm_addr = 5'(i + 10);
            tick();
            check("dm_hold", bus.dm_data_output, 64'd9);
        end

        // Adder/subtractor vectors
        vecs[0] = '{64'd7, 64'd5, 1'b0, 64'd12};
        vecs[1] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000};
        vecs[3] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
        vecs[6] = '{64'd100, 64'd100, 1'b1, 64'd0};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFF6, 64'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9};
        for (int i = 0; i < 8; i++) begin
            bus.as_factor_a = vecs[i].a; bus.as_factor_b = vecs[i].b; bus.as_operation = vecs[i].op;
            #1;
            check("alu_vec", bus.as_result, vecs[i].exp);
        end

        // Async reset pulse with a write pending
        bus.rf_write_en = 1'b1; bus.rf_write_addr = 5'd9; bus.rf_write_data = 64'h1111;
        tick();
        bus.rf_addr_a = 5'd9; bus.rf_write_data = 64'h2222;
        #1;
        check("rf9_before_reset", bus.rf_data_a, 64'h1111);
        reset = 1'b1;
        #1;
        model_clear();
        check("rf9_async_cleared", bus.rf_data_a, 64'h0);
        check("dm_async_cleared", bus.dm_data_output, 64'h0);
        reset = 1'b0;
        bus.rf_write_en = 1'b0;
        tick();
        check("rf9_stays_zero", bus.rf_data_a, 64'h0);
        bus.dm_addr = 5'd7; bus.dm_read = 1'b1;
        tick();
        check("mem7_cleared", bus.dm_data_output, 64'h0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            bus.rf_write_en     = 1'($urandom_range(0, 1));
            bus.rf_write_addr   = 5'($urandom_range(0, 31));
            bus.rf_write_data   = {$urandom(), $urandom()};
            bus.rf_addr_a       = ($urandom_range(0, 3) == 0) ? bus.rf_write_addr : 5'($urandom_range(0, 31));
            bus.rf_addr_b       = 5'($urandom_range(0, 31));
            bus.dm_addr         = 5'($urandom_range(0, 7));
            bus.dm_data_input   = {$urandom(), $urandom()};
            bus.dm_write_enable = 1'($urandom_range(0, 1));
            bus.dm_read         = 1'($urandom_range(0, 1));
            bus.as_factor_a     = {$urandom(), $urandom()};
            bus.as_factor_b     = ($urandom_range(0, 3) == 0) ? 64'(-1) : {$urandom(), $urandom()};
            bus.as_operation    = 1'($urandom_range(0, 1));
            #1;
            exp_r = bus.as_operation ? bus.as_factor_a - bus.as_factor_b : bus.as_factor_a + bus.as_factor_b;
            check("rand_alu", bus.as_result, exp_r);
            check("rand_rf_a_pre", bus.rf_data_a, rf_m[bus.rf_addr_a]);
            tick();
            check("rand_rf_a", bus.rf_data_a, rf_m[bus.rf_addr_a]);
            check("rand_rf_b", bus.rf_data_b, rf_m[bus.rf_addr_b]);
            check("rand_dm_out", bus.dm_data_output, dout_m);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
